// File: rtl/ftsd_scan_ctl_pkg.sv
// ftsd_scan_ctl_pkg: shared constants and types for the 14-segment
// display scan controller.
//   FTSD_DIGIT_NUM     number of multiplexed digits
//   FTSD_CTL_OFF       digit-enable pattern with every digit dark (active-low)
//   FTSD_BCD_BIT_WIDTH width of one BCD digit
//   ftsd_snap_t        one frame's snapshot: digits, dp requests, blank flag
//   lead_sup()         leading-zero suppression decision for one slot
package ftsd_scan_ctl_pkg;

    localparam int                FTSD_DIGIT_NUM     = 4;
    localparam int                FTSD_BCD_BIT_WIDTH = 4;
    localparam logic [3:0]        FTSD_CTL_OFF       = 4'b1111;

    typedef logic [FTSD_DIGIT_NUM-1:0][FTSD_BCD_BIT_WIDTH-1:0] ftsd_digits_t;

    typedef struct packed {
        ftsd_digits_t              d;   // d[0] is the rightmost digit
        logic [FTSD_DIGIT_NUM-1:0] dp;  // decimal-point requests, active-high
        logic                      bl;  // leading-zero suppression enable
    } ftsd_snap_t;

    // Digit s is dark when suppression is on and it and every digit to its
    // left are zero. The rightmost digit always shows so "0" stays visible.
    function automatic logic lead_sup(input ftsd_digits_t d, input logic bl,
                                      input logic [1:0] s);
        logic sup;
        sup = bl && (s != 2'd0);
        for (int k = 1; k < FTSD_DIGIT_NUM; k++) begin
            if (k >= int'(s) && d[k] != '0) sup = 1'b0;
        end
        return sup;
    endfunction

endpackage

// File: rtl/ftsd_scan_counter.sv
// ftsd_scan_counter: slot timing for the display scan.
//   clk, rst     clock and synchronous active-high reset
//   cnt_nxt      cycle-in-slot value for the coming cycle
//   slot_nxt     slot (digit) index for the coming cycle
//   frame_end    high on the cycle whose closing edge ends slot 3
//   frame_start  registered pulse on the first cycle of slot 0
module ftsd_scan_counter #(
    parameter int SCAN_DIV = 50000,
    localparam int CW      = $clog2(SCAN_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt_nxt,
    output logic [1:0]    slot_nxt,
    output logic          frame_end,
    output logic          frame_start
);

    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    slot;
    // Cleared by reset so the first edge after release lands on slot 0,
    // cnt 0 rather than skipping straight to cnt 1.
    logic          run;

    always_comb begin
        frame_end = run && (slot == 2'd3) && (cnt == LAST);
        cnt_nxt   = cnt + 1'b1;
        slot_nxt  = slot;
        if (!run) begin
            cnt_nxt  = '0;
            slot_nxt = 2'd0;
        end else if (cnt == LAST) begin
            cnt_nxt  = '0;
            slot_nxt = slot + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            slot        <= 2'd0;
            run         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            slot        <= slot_nxt;
            run         <= 1'b1;
            frame_start <= (slot_nxt == 2'd0) && (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/ftsd_scan_ctl.sv
// ftsd_scan_ctl: four-digit 14-segment display scan controller.
// Snapshots the digits once per frame, rotates one slot per digit, blanks
// all digits for BLANK_CYCLES at the start of each slot, and optionally
// suppresses leading zeros.
//   clk, rst        clock and synchronous active-high reset
//   in0..in3        BCD digits, in0 rightmost
//   dp_in           decimal-point requests, bit i for digit i
//   blank_lead      leading-zero suppression enable
//   bcd             BCD value of the current slot, to the decoder
//   ftsd_ctl        active-low digit enables
//   dp              active-low decimal point for the current slot
//   frame_start     pulse on the first cycle of slot 0
module ftsd_scan_ctl
    import ftsd_scan_ctl_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FTSD_BCD_BIT_WIDTH-1:0] in0,
    input  logic [FTSD_BCD_BIT_WIDTH-1:0] in1,
    input  logic [FTSD_BCD_BIT_WIDTH-1:0] in2,
    input  logic [FTSD_BCD_BIT_WIDTH-1:0] in3,
    input  logic [FTSD_DIGIT_NUM-1:0]     dp_in,
    input  logic                          blank_lead,
    output logic [FTSD_BCD_BIT_WIDTH-1:0] bcd,
    output logic [FTSD_DIGIT_NUM-1:0]     ftsd_ctl,
    output logic                          dp,
    output logic                          frame_start
);

    localparam int            CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_nxt;
    logic [1:0]    slot_nxt;
    logic          frame_end;

    ftsd_scan_counter #(.SCAN_DIV(SCAN_DIV)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .cnt_nxt     (cnt_nxt),
        .slot_nxt    (slot_nxt),
        .frame_end   (frame_end),
        .frame_start (frame_start)
    );

    ftsd_snap_t snap, snap_nxt;
    logic       off;

    // Outputs are registered from next-state, so the snapshot taken on the
    // frame-closing edge must already feed slot 0's first cycle.
    always_comb begin
        snap_nxt = snap;
        if (frame_end) begin
            snap_nxt.d  = {in3, in2, in1, in0};
            snap_nxt.dp = dp_in;
            snap_nxt.bl = blank_lead;
        end
        off = (cnt_nxt < BLANK_C) || lead_sup(snap_nxt.d, snap_nxt.bl, slot_nxt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap     <= '0;
            bcd      <= '0;
            ftsd_ctl <= FTSD_CTL_OFF;
            dp       <= 1'b1;
        end else begin
            snap     <= snap_nxt;
            bcd      <= snap_nxt.d[slot_nxt];
            ftsd_ctl <= off ? FTSD_CTL_OFF : ~(4'b0001 << slot_nxt);
            dp       <= off ? 1'b1 : ~snap_nxt.dp[slot_nxt];
        end
    end

endmodule
